// File: rtl/matrix_read_sequencer.sv
// Walks an n x n store in row-major order and streams each element with its
// indices through a 2-entry FIFO, so downstream stalls never drop or repeat data.
module matrix_read_sequencer #(
    parameter int n = 8,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(n) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_i,
    output logic [IDX_W-1:0]  rd_j,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_i,
    output logic [IDX_W-1:0]  out_j,
    output logic              out_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(n - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   i_cnt;
    logic [IDX_W-1:0]   j_cnt;
    logic               pend;
    logic [IDX_W-1:0]   pend_i;
    logic [IDX_W-1:0]   pend_j;
    logic [DATA_W-1:0]  fifo_data [2];
    logic [IDX_W-1:0]   fifo_i [2];
    logic [IDX_W-1:0]   fifo_j [2];
    logic [1:0]         count;
    logic               rptr;
    logic               wptr;
    logic [1:0]         occ;
    logic               pop;
    logic               last_issue;

    // Occupancy counts the in-flight read, so a FIFO slot is always free for it.
    assign occ        = count + {1'b0, pend};
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign rd_en      = (state == RUN) && ((occ - {1'b0, pop}) < 2'd2);
    assign last_issue = rd_en && (i_cnt == LAST) && (j_cnt == LAST);

    assign rd_i     = i_cnt;
    assign rd_j     = j_cnt;
    assign out_data = fifo_data[rptr];
    assign out_i    = fifo_i[rptr];
    assign out_j    = fifo_j[rptr];
    assign out_last = out_valid && (fifo_i[rptr] == LAST) && (fifo_j[rptr] == LAST);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            i_cnt        <= '0;
            j_cnt        <= '0;
            pend         <= 1'b0;
            pend_i       <= '0;
            pend_j       <= '0;
            count        <= 2'd0;
            rptr         <= 1'b0;
            wptr         <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_i[0]    <= '0;
            fifo_i[1]    <= '0;
            fifo_j[0]    <= '0;
            fifo_j[1]    <= '0;
        end else begin
            pend <= rd_en;
            if (rd_en) begin
                pend_i <= i_cnt;
                pend_j <= j_cnt;
            end

            if (pend) begin
                fifo_data[wptr] <= rd_data;
                fifo_i[wptr]    <= pend_i;
                fifo_j[wptr]    <= pend_j;
                wptr            <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, pend} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end else if (rd_en) begin
                        if (j_cnt == LAST) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_read_sequencer.md
Name: matrix_read_sequencer

Overview:
- Controller that walks an n x n matrix store in row-major order and streams each element, with its indices, to a downstream consumer such as the file writer.
- Drives the store's index and read-enable inputs; the store has 1-cycle read latency.
- Buffers returned data in a 2-entry FIFO so downstream backpressure never drops or duplicates an element.
- Sits between the result matrix storage and the output/writer stage; start/done is its control interface.

Parameters:
- n, 8, matrix dimension (n >= 1).
- DATA_W, 32, element width.
- IDX_W, $clog2(n)+1 (derived localparam, not overridable), index port width; one spare bit keeps n a power of two representable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a pass; sampled only in IDLE.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse after the last element is accepted.
- rd_en  output  1  read request to the store for (rd_i, rd_j).
- rd_i  output  IDX_W  row index of the current read.
- rd_j  output  IDX_W  column index of the current read.
- rd_data  input  DATA_W  store data, valid exactly 1 cycle after rd_en.
- out_valid  output  1  out_* holds a valid element.
- out_ready  input  1  consumer accepts; transfer = out_valid && out_ready.
- out_data  output  DATA_W  element value.
- out_i  output  IDX_W  element row.
- out_j  output  IDX_W  element column.
- out_last  output  1  high with element (n-1, n-1).

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - busy, done, rd_en, out_valid and out_last are 0; rd_i, rd_j, out_i, out_j and out_data are 0.
  - FIFO is emptied and the pending-read flag is cleared.
  - Reset mid-pass aborts the pass; the rd_data returned in the following cycle is ignored.
- States:
  - IDLE -> RUN when start is high; index counters are loaded to (0,0).
  - RUN -> DRAIN once read (n-1, n-1) has been issued.
  - DRAIN -> DONE on the transfer of the out_last element.
  - DONE -> IDLE unconditionally after 1 cycle; done = 1 only in DONE.
  - busy = 1 in RUN and DRAIN.
  - start outside IDLE is ignored, including during the DONE cycle.
- Occupancy: occ = FIFO entries (0..2) + pending read (0/1). pop = out_valid && out_ready.
- Read issue:
  - rd_en = (state == RUN) && (occ - pop < 2).
  - On issue, j increments; at j = n-1, j wraps to 0 and i increments.
  - The read of (n-1, n-1) moves the state to DRAIN, and the counters hold.
  - rd_i and rd_j show the current index whenever in RUN.
- Return path:
  - A pending flag is set on the cycle rd_en is high.
  - On the next edge, rd_data and its captured indices are pushed into the FIFO.
  - The head is visible on out_* from the following cycle.
  - A simultaneous push and pop is legal; the FIFO never overflows under the issue rule.
- Output stability: while out_valid && !out_ready, out_data, out_i, out_j and out_last hold stable.
- Timing with out_ready held 1 (start high in cycle T):
  - rd_en first high in T+1, with one read per cycle after that.
  - out_valid first high in T+3.
  - Last transfer in T+2+n².
  - done in T+3+n²; the block is back in IDLE at T+4+n².
- n = 1: a single element (0,0) with out_last = 1. RUN lasts 1 cycle.

Test Plan:
- Reset: assert rst for 2 cycles with start = 1 -> all outputs 0, state IDLE, no rd_en.
- n=4, matrix[i][j] = 4i+j+1, out_ready = 1, start pulse at cycle T:
  - 16 transfers with values 1..16 in row-major order, carrying (i,j).
  - out_last only on (3,3), value 16.
  - done single pulse at T+19, busy high T+1..T+18.
- Backpressure, n=4: out_ready pattern 1,0,0,1 repeating:
  - every element is delivered exactly once, in order, and held stable while stalled.
  - occ never exceeds 2.
  - rd_en is low whenever the FIFO is full and no pop occurs.
- Start while busy: pulse start at T+5 and in the DONE cycle -> no second pass and no extra rd_en; a later start in IDLE runs a full pass.
- Reset mid-run: assert rst at T+8 with out_ready = 0:
  - next cycle all outputs are 0 and returning rd_data is dropped.
  - a fresh start then delivers (0,0) first.
- n=1: start -> one transfer (0,0) with out_last = 1; done 1 cycle after the transfer.
